// File: rtl/fp_int_mul_lanes.sv
// Bit-serial FP16 x signed-INT multiplier with LANES weight lanes sharing one activation.
// Each lane accumulates mantissa shifts LSB first; the MSB beat subtracts (two's-complement weight).
module fp_int_mul_lanes #(
   parameter int ACT_WIDTH = 16,
   parameter int LANES     = 4,
   parameter int MAX_PREC  = 8,
   parameter int MANT_W    = 10 + MAX_PREC,
   parameter int PREC_W    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ACT_WIDTH-1:0]      act,
   input  logic [LANES-1:0]          w,
   input  logic                      valid,
   output logic                      in_ready,
   input  logic [PREC_W-1:0]         precision,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES-1:0]          sign_out,
   output logic [4:0]                exp_out,
   output logic [LANES*MANT_W-1:0]   mantissa_out
);

   localparam int CNT_W = $clog2(MAX_PREC + 1);
   localparam int ACC_W = MANT_W + 2;

   typedef enum logic {S_IDLE, S_ACC} state_t;

   state_t                          state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [CNT_W-1:0]                peff_q, peff_d;
   logic [ACT_WIDTH-1:0]            act_q, act_d;
   logic [LANES-1:0][ACC_W-1:0]     acc_q, acc_d;
   logic                            out_valid_q, out_valid_d;
   logic [LANES-1:0]                sign_q, sign_d;
   logic [4:0]                      exp_q, exp_d;
   logic [LANES*MANT_W-1:0]         mant_q, mant_d;

   logic                            beat, first, last;
   logic [CNT_W-1:0]                peff_in, peff_cur;
   logic [ACT_WIDTH-1:0]            act_cur;
   logic [10:0]                     m_cur;

   always_comb begin
      if (precision < PREC_W'(2))
         peff_in = CNT_W'(2);
      else if (precision > PREC_W'(MAX_PREC))
         peff_in = CNT_W'(MAX_PREC);
      else
         peff_in = CNT_W'(precision);
   end

   // On the first beat the live inputs are used, since they are only latched on that edge.
   always_comb begin
      in_ready = !out_valid_q || out_ready;
      beat     = valid && in_ready;
      first    = (state_q == S_IDLE);
      act_cur  = first ? act : act_q;
      peff_cur = first ? peff_in : peff_q;
      m_cur    = {act_cur[ACT_WIDTH-2 -: 5] != 5'd0, act_cur[9:0]};
      last     = beat && (cnt_q == peff_cur - CNT_W'(1));

      state_d  = state_q;
      cnt_d    = cnt_q;
      act_d    = act_q;
      peff_d   = peff_q;
      if (beat) begin
         state_d = last ? S_IDLE : S_ACC;
         cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
         if (first) begin
            act_d  = act;
            peff_d = peff_in;
         end
      end

      exp_d       = last ? act_q[ACT_WIDTH-2 -: 5] : exp_q;
      out_valid_d = last || (out_valid_q && !out_ready);
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [ACC_W-1:0]  term;
         logic [ACC_W-1:0]  sum;
         logic [MANT_W-1:0] mag;

         assign term = w[gi] ? (ACC_W'(m_cur) << cnt_q) : '0;
         assign sum  = last ? acc_q[gi] - term : acc_q[gi] + term;
         assign mag  = MANT_W'(sum[ACC_W-1] ? -sum : sum);

         assign acc_d[gi]  = !beat ? acc_q[gi] : (last ? '0 : sum);
         assign sign_d[gi] = last ? (act_q[ACT_WIDTH-1] ^ sum[ACC_W-1]) : sign_q[gi];
         assign mant_d[gi*MANT_W +: MANT_W] = last ? mag : mant_q[gi*MANT_W +: MANT_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         peff_q      <= '0;
         act_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         sign_q      <= '0;
         exp_q       <= '0;
         mant_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         peff_q      <= peff_d;
         act_q       <= act_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         mant_q      <= mant_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign sign_out     = sign_q;
   assign exp_out      = exp_q;
   assign mantissa_out = mant_q;

endmodule

// File: tb/tb_fp_int_mul_lanes.sv
// Bench for fp_int_mul_lanes: directed vector table, handshake/stall/reset sequences,
// and randomized groups scored against an integer-arithmetic reference model.
module tb_fp_int_mul_lanes;

   localparam int LANES    = 4;
   localparam int MAX_PREC = 8;
   localparam int MANT_W   = 10 + MAX_PREC;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic [15:0]             act = '0;
   logic [LANES-1:0]        w = '0;
   logic                    valid = 1'b0;
   logic                    in_ready;
   logic [3:0]              precision = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [LANES-1:0]        sign_out;
   logic [4:0]              exp_out;
   logic [LANES*MANT_W-1:0] mantissa_out;

   always #5 clk = ~clk;

   fp_int_mul_lanes #(
      .ACT_WIDTH(16), .LANES(LANES), .MAX_PREC(MAX_PREC), .MANT_W(MANT_W), .PREC_W(4)
   ) dut (
      .clk(clk), .rst(rst), .act(act), .w(w), .valid(valid), .in_ready(in_ready),
      .precision(precision), .out_valid(out_valid), .out_ready(out_ready),
      .sign_out(sign_out), .exp_out(exp_out), .mantissa_out(mantissa_out)
   );

   typedef struct packed {
      logic [4:0]              e;
      logic [LANES-1:0]        s;
      logic [LANES*MANT_W-1:0] m;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [3:0]  p;
      int          w0;
      int          w1;
      logic [4:0]  e;
      logic [3:0]  s;
      logic [17:0] m0;
      logic [17:0] m1;
   } tv_t;

   int   n_pass = 0;
   int   n_checks = 0;
   int   wts[LANES];
   res_t exp_q[$];
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, want);
   endtask

   function automatic int peff_of(input logic [3:0] p);
      if (p < 2) return 2;
      if (p > MAX_PREC) return MAX_PREC;
      return int'(p);
   endfunction

   // Reference: product = mantissa * (P-bit signed weight), reported as sign/magnitude.
   function automatic res_t model(input logic [15:0] a, input logic [3:0] p);
      res_t r;
      int pe, m, wv, prod;
      pe  = peff_of(p);
      r.e = a[14:10];
      m   = (a[14:10] != 0 ? 1024 : 0) + int'(a[9:0]);
      r.s = '0;
      r.m = '0;
      for (int l = 0; l < LANES; l++) begin
         wv = wts[l] & ((1 << pe) - 1);
         if (wv >= (1 << (pe - 1))) wv -= (1 << pe);
         prod = m * wv;
         r.s[l] = a[15] ^ (prod < 0);
         r.m[l*MANT_W +: MANT_W] = MANT_W'(prod < 0 ? -prod : prod);
      end
      return r;
   endfunction

   task automatic check_res(input string name, input res_t r);
      check({name, " valid"}, 128'(out_valid), 128'(1));
      check({name, " exp"}, 128'(exp_out), 128'(r.e));
      check({name, " sign"}, 128'(sign_out), 128'(r.s));
      for (int l = 0; l < LANES; l++)
         check($sformatf("%s mant%0d", name, l), 128'(mantissa_out[l*MANT_W +: MANT_W]),
               128'(r.m[l*MANT_W +: MANT_W]));
   endtask

   // Sends nb beats (0 = whole group); optional 3-cycle valid gap after beat stall_after.
   task automatic send_group(input logic [15:0] a, input logic [3:0] p,
                             input int stall_after, input int nb);
      int pe;
      pe = peff_of(p);
      if (nb == 0) nb = pe;
      for (int k = 0; k < nb; k++) begin
         act       = (k == 0) ? a : 16'($urandom);
         precision = (k == 0) ? p : 4'($urandom);
         for (int l = 0; l < LANES; l++) w[l] = 1'((wts[l] >> k) & 1);
         valid = 1'b1;
         @(posedge clk); #1;
         if (k == stall_after) begin
            valid = 1'b0;
            act   = 16'($urandom);
            repeat (3) @(posedge clk);
            #1;
         end
      end
      valid = 1'b0;
   endtask

   task automatic send_rand(input logic [15:0] a, input logic [3:0] p);
      int pe, tries;
      bit done;
      pe = peff_of(p);
      for (int k = 0; k < pe; k++) begin
         done  = 1'b0;
         tries = 0;
         while (!done) begin
            valid     = ($urandom_range(0, 3) != 0);
            act       = (k == 0) ? a : 16'($urandom);
            precision = (k == 0) ? p : 4'($urandom);
            for (int l = 0; l < LANES; l++) w[l] = 1'((wts[l] >> k) & 1);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            done = valid && in_ready;
            @(posedge clk); #1;
            tries++;
            if (!done && tries > 50) begin
               check("beat accept timeout", 128'(0), 128'(1));
               done = 1'b1;
            end
         end
      end
      valid = 1'b0;
      exp_q.push_back(model(a, p));
   endtask

   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         res_t got, want;
         got = {exp_out, sign_out, mantissa_out};
         if (exp_q.size() == 0) begin
            check("unexpected result", 128'(got), 128'(0));
         end else begin
            want = exp_q.pop_front();
            check("rand result", 128'(got), 128'(want));
         end
      end
   end

   tv_t  tv[7];
   res_t ra, rb;

   initial begin
      tv[0] = '{16'h1234, 4'd4,    5,   -3, 5'b00100, 4'b0010, 18'h01F04, 18'h0129C};
      tv[1] = '{16'hF234, 4'd4,    7,   -8, 5'b11100, 4'b1101, 18'h02B6C, 18'h031A0};
      tv[2] = '{16'h3BFF, 4'd8, -128,    0, 5'b01110, 4'b0001, 18'h3FF80, 18'h00000};
      tv[3] = '{16'h3BFF, 4'd15, -128,   0, 5'b01110, 4'b0001, 18'h3FF80, 18'h00000};
      tv[4] = '{16'h3BFF, 4'd1,   -1,    1, 5'b01110, 4'b0001, 18'h007FF, 18'h007FF};
      tv[5] = '{16'h0001, 4'd2,    1,    0, 5'b00000, 4'b0000, 18'h00001, 18'h00000};
      tv[6] = '{16'h8000, 4'd2,    0,   -1, 5'b00000, 4'b1111, 18'h00000, 18'h00000};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 128'(out_valid), 128'(0));
      check("reset in_ready", 128'(in_ready), 128'(1));
      check("reset sign", 128'(sign_out), 128'(0));
      check("reset exp", 128'(exp_out), 128'(0));
      check("reset mant", 128'(mantissa_out), 128'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed vector table
      for (int i = 0; i < 7; i++) begin
         wts = '{tv[i].w0, tv[i].w1, 0, 0};
         send_group(tv[i].a, tv[i].p, -1, 0);
         check($sformatf("tv%0d valid", i), 128'(out_valid), 128'(1));
         check($sformatf("tv%0d exp", i), 128'(exp_out), 128'(tv[i].e));
         check($sformatf("tv%0d sign", i), 128'(sign_out), 128'(tv[i].s));
         check($sformatf("tv%0d mant0", i), 128'(mantissa_out[0 +: MANT_W]), 128'(tv[i].m0));
         check($sformatf("tv%0d mant1", i), 128'(mantissa_out[MANT_W +: MANT_W]), 128'(tv[i].m1));
         check($sformatf("tv%0d mant23", i), 128'(mantissa_out[2*MANT_W +: 2*MANT_W]), 128'(0));
      end

      // Backpressure: group B waits behind an unconsumed result A
      wts = '{5, -3, 6, -7};
      ra  = model(16'h1234, 4'd4);
      send_group(16'h1234, 4'd4, -1, 0);
      check_res("bp A", ra);
      wts = '{7, -8, 1, 2};
      rb  = model(16'hF234, 4'd4);
      out_ready = 1'b0;
      act = 16'hF234;
      precision = 4'd4;
      for (int l = 0; l < LANES; l++) w[l] = 1'(wts[l] & 1);
      valid = 1'b1;
      #1;
      check("bp in_ready low", 128'(in_ready), 128'(0));
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("bp hold valid", 128'(out_valid), 128'(1));
         check("bp hold mant", 128'(mantissa_out), 128'(ra.m));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp A consumed", 128'(out_valid), 128'(0));
      for (int k = 1; k < 4; k++) begin
         act = 16'($urandom);
         for (int l = 0; l < LANES; l++) w[l] = 1'((wts[l] >> k) & 1);
         @(posedge clk); #1;
         if (k < 3) check("bp B pending", 128'(out_valid), 128'(0));
      end
      valid = 1'b0;
      check_res("bp B", rb);

      // Mid-group stall of three cycles
      wts = '{-77, 100, 33, -2};
      send_group(16'h4C1D, 4'd8, 1, 0);
      check_res("stall", model(16'h4C1D, 4'd8));

      // Reset after two beats discards the partial group
      wts = '{3, -5, 7, -1};
      send_group(16'h5A5A, 4'd6, -1, 2);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("midrst out_valid", 128'(out_valid), 128'(0));
      check("midrst sign", 128'(sign_out), 128'(0));
      check("midrst exp", 128'(exp_out), 128'(0));
      check("midrst mant", 128'(mantissa_out), 128'(0));
      wts = '{-9, 12, 25, -31};
      send_group(16'hB3C7, 4'd6, -1, 0);
      check_res("after rst", model(16'hB3C7, 4'd6));

      // Randomized groups with random gaps and downstream backpressure
      @(posedge clk); #1;
      mon_en = 1'b1;
      for (int g = 0; g < 40; g++) begin
         logic [15:0] a;
         a = 16'($urandom);
         if ($urandom_range(0, 3) == 0) a[14:10] = 5'd0;
         for (int l = 0; l < LANES; l++) wts[l] = int'($urandom);
         send_rand(a, 4'($urandom_range(0, 15)));
      end
      valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check("rand drained", 128'(exp_q.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
